// File: rtl/clk_mode_pkg.sv
// Shared types for the powersave clock-mode sequencer.
// State encoding plus the default counter-width helper.
package clk_mode_pkg;

  typedef enum logic [2:0] {
    S_LOCK,
    S_RUN,
    S_DRAIN,
    S_SWITCH,
    S_SETTLE
  } state_t;

  function automatic int cnt_w_calc(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_mode_sequencer.sv
// Sequences the 2x clock powersave mux: quiesce, gate, flip, settle, ungate.
// Optional drain watchdog enabled by defining CLK_MODE_TIMEOUT_EN.
module clk_mode_sequencer
  import clk_mode_pkg::*;
#(
  parameter int LOCK_CYCLES    = 256,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = cnt_w_calc(
    LOCK_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic ps_req,
  input  logic test_mode,
  input  logic quiesce_ack,
  output logic quiesce_req,
  output logic clk_en,
  output logic powersave,
  output logic ps_ack,
  output logic busy,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] LOCK_LAST =
    CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             qreq_n, clk_en_n, ps_n;
  logic             ack_n, busy_n;
  logic             target, target_n;
  logic             armed;

`ifdef CLK_MODE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  logic terr_q, terr_n, armed_n;
  assign timeout_err = terr_q;
`else
  assign armed       = 1'b1;
  assign timeout_err = 1'b0;
`endif

  // Saturating increment; the counter never wraps.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    qreq_n   = quiesce_req;
    clk_en_n = clk_en;
    ps_n     = powersave;
    ack_n    = 1'b0;
    target_n = target;
`ifdef CLK_MODE_TIMEOUT_EN
    terr_n   = terr_q;
    armed_n  = armed | (ps_req == powersave);
`endif
    unique case (state)
      S_LOCK: begin
        cnt_n = cnt_inc;
        if (cnt == LOCK_LAST) begin
          clk_en_n = 1'b1;
          state_n  = S_RUN;
        end
      end
      S_RUN: begin
        if (ps_req != powersave && !test_mode
            && armed) begin
          target_n = ps_req;
          qreq_n   = 1'b1;
          cnt_n    = '0;
          state_n  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_n = cnt_inc;
        if (quiesce_ack) begin
          clk_en_n = 1'b0;
          state_n  = S_SWITCH;
        end
`ifdef CLK_MODE_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          // Give up; stay disarmed until the request matches again.
          qreq_n  = 1'b0;
          terr_n  = 1'b1;
          armed_n = 1'b0;
          state_n = S_RUN;
        end
`endif
      end
      S_SWITCH: begin
        ps_n    = target;
        cnt_n   = '0;
        state_n = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_n = cnt_inc;
        if (cnt == SETTLE_LAST) begin
          clk_en_n = 1'b1;
          qreq_n   = 1'b0;
          ack_n    = 1'b1;
          state_n  = S_RUN;
        end
      end
      default: state_n = S_LOCK;
    endcase
    busy_n = (state_n != S_RUN);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= S_LOCK;
      cnt         <= '0;
      quiesce_req <= 1'b0;
      clk_en      <= 1'b0;
      powersave   <= 1'b0;
      ps_ack      <= 1'b0;
      busy        <= 1'b1;
      target      <= 1'b0;
`ifdef CLK_MODE_TIMEOUT_EN
      terr_q      <= 1'b0;
      armed       <= 1'b1;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      quiesce_req <= qreq_n;
      clk_en      <= clk_en_n;
      powersave   <= ps_n;
      ps_ack      <= ack_n;
      busy        <= busy_n;
      target      <= target_n;
`ifdef CLK_MODE_TIMEOUT_EN
      terr_q      <= terr_n;
      armed       <= armed_n;
`endif
    end
  end

endmodule

// File: tb/tb_clk_mode_sequencer.sv
// Directed bench for clk_mode_sequencer (LOCK=8, SETTLE=4, TIMEOUT=16).
// Watchdog scenario runs only when CLK_MODE_TIMEOUT_EN is defined.
module tb_clk_mode_sequencer;

  logic clk = 1'b0;
  logic sys_rst, ps_req, test_mode, quiesce_ack;
  logic quiesce_req, clk_en, powersave;
  logic ps_ack, busy, timeout_err;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  clk_mode_sequencer #(
    .LOCK_CYCLES   (8),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .ps_req     (ps_req),
    .test_mode  (test_mode),
    .quiesce_ack(quiesce_ack),
    .quiesce_req(quiesce_req),
    .clk_en     (clk_en),
    .powersave  (powersave),
    .ps_ack     (ps_ack),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    ps_req = 1'b0;
    test_mode = 1'b0;
    quiesce_ack = 1'b0;
    repeat (3) step();
    total++;
    if ({clk_en, powersave, busy, quiesce_req,
         ps_ack, timeout_err} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=001000",
        {clk_en, powersave, busy, quiesce_req,
         ps_ack, timeout_err});
    end
    sys_rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if (clk_en !== (i == 8) || ps_ack !== 1'b0) begin
        bad++;
        $display("FAIL lock_edge%0d clk_en=%b ps_ack=%b exp_en=%b",
          i, clk_en, ps_ack, (i == 8));
      end
    end
    total++;
    if (busy !== 1'b0 || powersave !== 1'b0) begin
      bad++;
      $display("FAIL lock_done busy=%b ps=%b exp 0 0",
        busy, powersave);
    end
  endtask

  // mode 0: plain, 1: ps_req glitches during settle,
  // 2: ps_req left opposite so a new sequence follows.
  task automatic do_seq(input logic tgt, input int dly,
                        input int mode);
    ps_req = tgt;
    step();
    total++;
    if (quiesce_req !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL seq%b_start qreq=%b busy=%b exp 1 1",
        tgt, quiesce_req, busy);
    end
    for (int i = 0; i < dly; i++) begin
      step();
      total++;
      if (clk_en !== 1'b1) begin
        bad++;
        $display("FAIL seq%b_drain clk_en=%b exp 1", tgt, clk_en);
      end
    end
    quiesce_ack = 1'b1;
    step();
    total++;
    if (clk_en !== 1'b0 || powersave !== ~tgt) begin
      bad++;
      $display("FAIL seq%b_gate clk_en=%b ps=%b exp 0 %b",
        tgt, clk_en, powersave, ~tgt);
    end
    quiesce_ack = 1'b0;
    step();
    total++;
    if (clk_en !== 1'b0 || powersave !== tgt) begin
      bad++;
      $display("FAIL seq%b_flip clk_en=%b ps=%b exp 0 %b",
        tgt, clk_en, powersave, tgt);
    end
    for (int i = 1; i <= 4; i++) begin
      if (mode != 0 && i == 1) ps_req = ~tgt;
      if (mode == 1 && i == 2) ps_req = tgt;
      step();
      total++;
      if (clk_en !== (i == 4) || ps_ack !== (i == 4)) begin
        bad++;
        $display("FAIL seq%b_settle%0d clk_en=%b ack=%b exp %b",
          tgt, i, clk_en, ps_ack, (i == 4));
      end
    end
    total++;
    if (quiesce_req !== 1'b0 || powersave !== tgt) begin
      bad++;
      $display("FAIL seq%b_done qreq=%b ps=%b exp 0 %b",
        tgt, quiesce_req, powersave, tgt);
    end
    step();
    total++;
    if (ps_ack !== 1'b0 || quiesce_req !== (mode == 2)
        || busy !== (mode == 2) || powersave !== tgt) begin
      bad++;
      $display("FAIL seq%b_after ack=%b qreq=%b busy=%b ps=%b",
        tgt, ps_ack, quiesce_req, busy, powersave);
    end
  endtask

  task automatic test_ps_up();
    do_seq(1'b1, 3, 0);
  endtask

  task automatic test_ps_down();
    do_seq(1'b0, 0, 0);
  endtask

  task automatic test_settle_toggle();
    do_seq(1'b1, 2, 1);
    repeat (3) step();
    total++;
    if (quiesce_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL toggle_no_resequence qreq=%b busy=%b exp 0 0",
        quiesce_req, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_seq(1'b0, 1, 2);
    do_seq(1'b1, 1, 0);
  endtask

  task automatic test_test_mode();
    test_mode = 1'b1;
    ps_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (quiesce_req !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL tm_block qreq=%b busy=%b exp 0 0",
          quiesce_req, busy);
      end
    end
    test_mode = 1'b0;
    step();
    total++;
    if (quiesce_req !== 1'b1) begin
      bad++;
      $display("FAIL tm_release qreq=%b exp 1", quiesce_req);
    end
    test_mode = 1'b1;
    quiesce_ack = 1'b1;
    step();
    quiesce_ack = 1'b0;
    repeat (5) step();
    total++;
    if (clk_en !== 1'b1 || ps_ack !== 1'b1
        || powersave !== 1'b0) begin
      bad++;
      $display("FAIL tm_inflight en=%b ack=%b ps=%b exp 1 1 0",
        clk_en, ps_ack, powersave);
    end
    test_mode = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    ps_req = 1'b1;
    step();
    quiesce_ack = 1'b1;
    step();
    quiesce_ack = 1'b0;
    step();
    step();
    sys_rst = 1'b1;
    ps_req = 1'b0;
    step();
    total++;
    if ({clk_en, powersave, busy, quiesce_req} !== 4'b0010) begin
      bad++;
      $display("FAIL rst_mid got=%b exp=0010",
        {clk_en, powersave, busy, quiesce_req});
    end
    sys_rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if (clk_en !== (i == 8)) begin
        bad++;
        $display("FAIL relock_edge%0d clk_en=%b exp %b",
          i, clk_en, (i == 8));
      end
    end
  endtask

`ifdef CLK_MODE_TIMEOUT_EN
  task automatic test_timeout();
    ps_req = 1'b1;
    step();
    for (int i = 1; i <= 16; i++) begin
      step();
      total++;
      if (quiesce_req !== (i < 16)
          || timeout_err !== (i == 16)) begin
        bad++;
        $display("FAIL to_cycle%0d qreq=%b terr=%b",
          i, quiesce_req, timeout_err);
      end
    end
    total++;
    if ({powersave, clk_en, ps_ack, busy} !== 4'b0100) begin
      bad++;
      $display("FAIL to_state got=%b exp=0100",
        {powersave, clk_en, ps_ack, busy});
    end
    repeat (4) step();
    total++;
    if (quiesce_req !== 1'b0) begin
      bad++;
      $display("FAIL to_no_retry qreq=%b exp 0", quiesce_req);
    end
    ps_req = 1'b0;
    step();
    ps_req = 1'b1;
    step();
    total++;
    if (quiesce_req !== 1'b1) begin
      bad++;
      $display("FAIL to_rearm qreq=%b exp 1", quiesce_req);
    end
    quiesce_ack = 1'b1;
    step();
    quiesce_ack = 1'b0;
    repeat (5) step();
    total++;
    if (powersave !== 1'b1 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky ps=%b terr=%b exp 1 1",
        powersave, timeout_err);
    end
  endtask
`else
  task automatic test_timeout();
    ps_req = 1'b1;
    step();
    repeat (40) step();
    total++;
    if (quiesce_req !== 1'b1 || timeout_err !== 1'b0
        || clk_en !== 1'b1) begin
      bad++;
      $display("FAIL no_to_wait qreq=%b terr=%b en=%b exp 1 0 1",
        quiesce_req, timeout_err, clk_en);
    end
    quiesce_ack = 1'b1;
    step();
    quiesce_ack = 1'b0;
    repeat (5) step();
    total++;
    if (powersave !== 1'b1 || ps_ack !== 1'b1) begin
      bad++;
      $display("FAIL no_to_finish ps=%b ack=%b exp 1 1",
        powersave, ps_ack);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ps_up();
    test_ps_down();
    test_settle_toggle();
    test_back_to_back();
    test_test_mode();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
